// File: rtl/fi_result_checker.sv
// Registered FIFO with flush; a write to a full FIFO is accepted only alongside a read.
// Read side is valid/ready; the writer sees wr_rdy low when a write would be lost.
module fi_fifo #(
   parameter int W         = 8,
   parameter int LOG_DEPTH = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         wr_vld,
   output logic         wr_rdy,
   input  logic [W-1:0] wr_dat,
   output logic         rd_vld,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat
);
   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] PTR_ONE = {{LOG_DEPTH{1'b0}}, 1'b1};

   logic [W-1:0]       mem_q [DEPTH];
   logic [W-1:0]       mem_d [DEPTH];
   logic [LOG_DEPTH:0] wr_ptr_q;
   logic [LOG_DEPTH:0] wr_ptr_d;
   logic [LOG_DEPTH:0] rd_ptr_q;
   logic [LOG_DEPTH:0] rd_ptr_d;
   logic               empty;
   logic               full;
   logic               pop;
   logic               push;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                 (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
      rd_vld   = !empty;
      // Head data is forced to zero when empty so idle outputs stay quiet.
      rd_dat   = empty ? '0 : mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
      pop      = rd_vld && rd_rdy;
      wr_rdy   = !full || pop;
      push     = wr_vld && wr_rdy;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q[LOG_DEPTH-1:0]] = wr_dat;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end
endmodule

// Golden/faulty lane comparator with run statistics and a mismatch-record FIFO.
// Stats update one cycle after an accepted sample; input never stalls, FIFO overflow is counted.
module fi_result_checker #(
   parameter int DATA_W    = 16,
   parameter int LANES     = 2,
   parameter int CNT_W     = 32,
   parameter int LOG_DEPTH = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [CNT_W-1:0]        total_samples,
   input  logic                    in_valid,
   input  logic [LANES*DATA_W-1:0] gm_data,
   input  logic [LANES*DATA_W-1:0] fm_data,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        sample_cnt,
   output logic [CNT_W-1:0]        mismatch_cnt,
   output logic [CNT_W-1:0]        dropped_cnt,
   output logic [CNT_W-1:0]        first_mm_idx,
   output logic                    mm_valid,
   input  logic                    mm_ready,
   output logic [CNT_W-1:0]        mm_idx,
   output logic [LANES-1:0]        mm_lane_mask,
   output logic [LANES*DATA_W-1:0] mm_gm,
   output logic [LANES*DATA_W-1:0] mm_fm
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   typedef struct packed {
      logic [CNT_W-1:0]        idx;
      logic [LANES-1:0]        mask;
      logic [LANES*DATA_W-1:0] gm;
      logic [LANES*DATA_W-1:0] fm;
   } mm_rec_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] total_d;
   logic [CNT_W-1:0] sample_cnt_q;
   logic [CNT_W-1:0] sample_cnt_d;
   logic [CNT_W-1:0] mismatch_cnt_q;
   logic [CNT_W-1:0] mismatch_cnt_d;
   logic [CNT_W-1:0] dropped_cnt_q;
   logic [CNT_W-1:0] dropped_cnt_d;
   logic [CNT_W-1:0] first_mm_idx_q;
   logic [CNT_W-1:0] first_mm_idx_d;
   logic [LANES-1:0] lane_mask;
   logic             is_mm;
   logic             fifo_flush;
   logic             rec_wr_vld;
   logic             rec_wr_rdy;
   logic             rec_rd_vld;
   mm_rec_t          rec_wr_dat;
   mm_rec_t          rec_rd_dat;

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_mask[i] = (gm_data[i*DATA_W +: DATA_W] != fm_data[i*DATA_W +: DATA_W]);
      end
      is_mm = (lane_mask != '0);
   end

   assign rec_wr_dat = '{idx: sample_cnt_q, mask: lane_mask, gm: gm_data, fm: fm_data};

   always_comb begin
      state_d        = state_q;
      total_d        = total_q;
      sample_cnt_d   = sample_cnt_q;
      mismatch_cnt_d = mismatch_cnt_q;
      dropped_cnt_d  = dropped_cnt_q;
      first_mm_idx_d = first_mm_idx_q;
      fifo_flush     = 1'b0;
      rec_wr_vld     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               total_d        = total_samples;
               sample_cnt_d   = '0;
               mismatch_cnt_d = '0;
               dropped_cnt_d  = '0;
               first_mm_idx_d = CNT_MAX;
               fifo_flush     = 1'b1;
               state_d        = (total_samples == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               if (sample_cnt_q != CNT_MAX) begin
                  sample_cnt_d = sample_cnt_q + CNT_ONE;
               end
               if (sample_cnt_d == total_q) begin
                  state_d = ST_DONE;
               end
               if (is_mm) begin
                  rec_wr_vld = 1'b1;
                  if (mismatch_cnt_q != CNT_MAX) begin
                     mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
                  end
                  if (first_mm_idx_q == CNT_MAX) begin
                     first_mm_idx_d = sample_cnt_q;
                  end
                  // Full FIFO with no same-cycle pop: record is lost, only counted.
                  if (!rec_wr_rdy && (dropped_cnt_q != CNT_MAX)) begin
                     dropped_cnt_d = dropped_cnt_q + CNT_ONE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         total_q        <= '0;
         sample_cnt_q   <= '0;
         mismatch_cnt_q <= '0;
         dropped_cnt_q  <= '0;
         first_mm_idx_q <= CNT_MAX;
      end else begin
         state_q        <= state_d;
         total_q        <= total_d;
         sample_cnt_q   <= sample_cnt_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         dropped_cnt_q  <= dropped_cnt_d;
         first_mm_idx_q <= first_mm_idx_d;
      end
   end

   fi_fifo #(
      .W         ($bits(mm_rec_t)),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_mm_fifo (
      .clock  (clock),
      .reset  (reset),
      .flush  (fifo_flush),
      .wr_vld (rec_wr_vld),
      .wr_rdy (rec_wr_rdy),
      .wr_dat (rec_wr_dat),
      .rd_vld (rec_rd_vld),
      .rd_rdy (mm_ready),
      .rd_dat (rec_rd_dat)
   );

   assign busy         = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign sample_cnt   = sample_cnt_q;
   assign mismatch_cnt = mismatch_cnt_q;
   assign dropped_cnt  = dropped_cnt_q;
   assign first_mm_idx = first_mm_idx_q;
   assign mm_valid     = rec_rd_vld;
   assign mm_idx       = rec_rd_dat.idx;
   assign mm_lane_mask = rec_rd_dat.mask;
   assign mm_gm        = rec_rd_dat.gm;
   assign mm_fm        = rec_rd_dat.fm;
endmodule

// File: tb/tb_fi_result_checker.sv
// Bench for fi_result_checker: vector table, directed corner sequences, random runs vs a queue model.
module tb_fi_result_checker;
   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] total_samples;
   logic        in_valid;
   logic [31:0] gm_data;
   logic [31:0] fm_data;
   logic        busy;
   logic        done;
   logic [31:0] sample_cnt;
   logic [31:0] mismatch_cnt;
   logic [31:0] dropped_cnt;
   logic [31:0] first_mm_idx;
   logic        mm_valid;
   logic        mm_ready;
   logic [31:0] mm_idx;
   logic [1:0]  mm_lane_mask;
   logic [31:0] mm_gm;
   logic [31:0] mm_fm;

   int checks = 0;
   int errors = 0;

   fi_result_checker dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .total_samples (total_samples),
      .in_valid      (in_valid),
      .gm_data       (gm_data),
      .fm_data       (fm_data),
      .busy          (busy),
      .done          (done),
      .sample_cnt    (sample_cnt),
      .mismatch_cnt  (mismatch_cnt),
      .dropped_cnt   (dropped_cnt),
      .first_mm_idx  (first_mm_idx),
      .mm_valid      (mm_valid),
      .mm_ready      (mm_ready),
      .mm_idx        (mm_idx),
      .mm_lane_mask  (mm_lane_mask),
      .mm_gm         (mm_gm),
      .mm_fm         (mm_fm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   // Reference model: run flag, done flag, counters and a queue of buffered records.
   typedef struct {
      logic [31:0] idx;
      logic [1:0]  mask;
      logic [31:0] gm;
      logic [31:0] fm;
   } rec_t;

   bit          m_run;
   bit          m_done;
   logic [31:0] m_total;
   logic [31:0] m_sc;
   logic [31:0] m_mmc;
   logic [31:0] m_drop;
   logic [31:0] m_first;
   rec_t        m_q[$];

   function automatic logic [31:0] sat_inc(logic [31:0] x);
      return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
   endfunction

   function automatic void model_step(bit rst, bit st, logic [31:0] tot, bit iv,
                                      logic [31:0] g, logic [31:0] f, bit rdy);
      bit   popped;
      int   occ;
      rec_t r;
      if (rst) begin
         m_run = 0; m_done = 0; m_total = 0; m_sc = 0; m_mmc = 0; m_drop = 0;
         m_first = 32'hFFFF_FFFF;
         m_q.delete();
         return;
      end
      occ    = m_q.size();
      popped = (occ != 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (!m_run && st) begin
         m_total = tot; m_sc = 0; m_mmc = 0; m_drop = 0; m_first = 32'hFFFF_FFFF;
         m_q.delete();
         m_run  = (tot != 0);
         m_done = (tot == 0);
      end else if (m_run && iv) begin
         r.idx  = m_sc;
         r.mask = {g[31:16] != f[31:16], g[15:0] != f[15:0]};
         r.gm   = g;
         r.fm   = f;
         if (r.mask != 2'b00) begin
            m_mmc = sat_inc(m_mmc);
            if (m_first == 32'hFFFF_FFFF) m_first = m_sc;
            if (occ < 8 || popped) m_q.push_back(r);
            else m_drop = sat_inc(m_drop);
         end
         m_sc = m_sc + 32'd1;
         if (m_sc == m_total) begin
            m_run  = 0;
            m_done = 1;
         end
      end
   endfunction

   function automatic void check_model(string tag);
      chk({tag, " busy"}, 32'(busy), 32'(m_run));
      chk({tag, " done"}, 32'(done), 32'(m_done));
      chk({tag, " sample_cnt"}, sample_cnt, m_sc);
      chk({tag, " mismatch_cnt"}, mismatch_cnt, m_mmc);
      chk({tag, " dropped_cnt"}, dropped_cnt, m_drop);
      chk({tag, " first_mm_idx"}, first_mm_idx, m_first);
      chk({tag, " mm_valid"}, 32'(mm_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0 && mm_valid) begin
         chk({tag, " mm_idx"}, mm_idx, m_q[0].idx);
         chk({tag, " mm_lane_mask"}, 32'(mm_lane_mask), 32'(m_q[0].mask));
         chk({tag, " mm_gm"}, mm_gm, m_q[0].gm);
         chk({tag, " mm_fm"}, mm_fm, m_q[0].fm);
      end
   endfunction

   task automatic cycle(string tag, bit rst, bit st, logic [31:0] tot, bit iv,
                        logic [31:0] g, logic [31:0] f, bit rdy);
      reset = rst; start = st; total_samples = tot; in_valid = iv;
      gm_data = g; fm_data = f; mm_ready = rdy;
      model_step(rst, st, tot, iv, g, f, rdy);
      @(posedge clock);
      #1;
      check_model(tag);
   endtask

   typedef struct {
      logic        st;
      logic [31:0] tot;
      logic        iv;
      logic [31:0] g;
      logic [31:0] f;
      logic        rdy;
      logic        e_busy;
      logic        e_done;
      logic [31:0] e_sc;
      logic [31:0] e_mmc;
      logic [31:0] e_first;
      logic        e_mmv;
      logic [31:0] e_idx;
      logic [1:0]  e_mask;
      logic [31:0] e_gm;
      logic [31:0] e_fm;
   } vec_t;

   function automatic vec_t mkv(logic st, logic [31:0] tot, logic iv, logic [31:0] g,
                                logic [31:0] f, logic rdy, logic e_busy, logic e_done,
                                logic [31:0] e_sc, logic [31:0] e_mmc, logic [31:0] e_first,
                                logic e_mmv, logic [31:0] e_idx, logic [1:0] e_mask,
                                logic [31:0] e_gm, logic [31:0] e_fm);
      vec_t v;
      v.st = st; v.tot = tot; v.iv = iv; v.g = g; v.f = f; v.rdy = rdy;
      v.e_busy = e_busy; v.e_done = e_done; v.e_sc = e_sc; v.e_mmc = e_mmc;
      v.e_first = e_first; v.e_mmv = e_mmv; v.e_idx = e_idx; v.e_mask = e_mask;
      v.e_gm = e_gm; v.e_fm = e_fm;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [31:0] k;
      logic [31:0] last_idx;
      int          pops;

      // Rows: st tot iv gm fm rdy | busy done sc mmc first mmv idx mask gm fm
      vecs.push_back(mkv(1, 4, 0, 0, 0, 0,                     1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 4; i++)
         vecs.push_back(mkv(0, 0, 1, 32'h0006_FFF4, 32'h0006_FFF4, 0,
                            i != 4, i == 4, 32'(i), 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 0, 0, 0,                     0, 1, 4, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 3, 0, 0, 0, 0,                     1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 1, 32'h0010_0020, 32'h0010_0020, 0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 1, 32'h0010_0020, 32'h0010_0021, 0, 1, 0, 2, 1, 1, 1, 1, 2'b01, 32'h0010_0020, 32'h0010_0021));
      vecs.push_back(mkv(0, 0, 1, 32'h0010_0020, 32'h0010_0020, 0, 0, 1, 3, 1, 1, 1, 1, 2'b01, 32'h0010_0020, 32'h0010_0021));
      vecs.push_back(mkv(0, 0, 0, 0, 0, 1,                     0, 1, 3, 1, 1, 0, 0, 0, 0, 0));

      // Reset state
      cycle("rst0", 1, 0, 0, 0, 0, 0, 0);
      cycle("rst1", 1, 0, 0, 0, 0, 0, 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset mm_valid", 32'(mm_valid), 0);
      chk("reset first_mm_idx", first_mm_idx, 32'hFFFF_FFFF);
      chk("reset mm_idx", mm_idx, 0);
      chk("reset mm_lane_mask", 32'(mm_lane_mask), 0);
      chk("reset mm_gm", mm_gm, 0);
      chk("reset mm_fm", mm_fm, 0);

      foreach (vecs[i]) begin
         cycle($sformatf("vec%0d model", i), 0, vecs[i].st, vecs[i].tot, vecs[i].iv,
               vecs[i].g, vecs[i].f, vecs[i].rdy);
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
         chk($sformatf("vec%0d sample_cnt", i), sample_cnt, vecs[i].e_sc);
         chk($sformatf("vec%0d mismatch_cnt", i), mismatch_cnt, vecs[i].e_mmc);
         chk($sformatf("vec%0d first_mm_idx", i), first_mm_idx, vecs[i].e_first);
         chk($sformatf("vec%0d mm_valid", i), 32'(mm_valid), 32'(vecs[i].e_mmv));
         if (vecs[i].e_mmv) begin
            chk($sformatf("vec%0d mm_idx", i), mm_idx, vecs[i].e_idx);
            chk($sformatf("vec%0d mm_lane_mask", i), 32'(mm_lane_mask), 32'(vecs[i].e_mask));
            chk($sformatf("vec%0d mm_gm", i), mm_gm, vecs[i].e_gm);
            chk($sformatf("vec%0d mm_fm", i), mm_fm, vecs[i].e_fm);
         end
      end

      // Overflow: 12 mismatches into an 8-deep FIFO with no drain
      cycle("ovf start", 0, 1, 12, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         k = 32'(i);
         cycle("ovf fill", 0, 0, 0, 1, {k[15:0], k[15:0] + 16'd1}, {k[15:0] ^ 16'h0100, k[15:0] + 16'd1}, 0);
      end
      chk("ovf mismatch_cnt", mismatch_cnt, 12);
      chk("ovf dropped_cnt", dropped_cnt, 4);
      chk("ovf done", 32'(done), 1);
      chk("ovf head mask", 32'(mm_lane_mask), 32'(2'b10));
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d mm_valid", i), 32'(mm_valid), 1);
         chk($sformatf("drain%0d mm_idx", i), mm_idx, 32'(i));
         cycle("drain", 0, 0, 0, 0, 0, 0, 1);
      end
      chk("drain empty mm_valid", 32'(mm_valid), 0);
      chk("drain counters kept", mismatch_cnt, 12);

      // Full FIFO with a pop and a mismatching push in the same cycle
      cycle("full start", 0, 1, 10, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++)
         cycle("full fill", 0, 0, 0, 1, 32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i), 0);
      chk("full dropped before", dropped_cnt, 1);
      cycle("full pushpop", 0, 0, 0, 1, 32'h1111_0009, 32'h2222_0009, 1);
      chk("full pushpop dropped", dropped_cnt, 1);
      chk("full pushpop mismatch_cnt", mismatch_cnt, 10);
      chk("full pushpop head idx", mm_idx, 1);
      pops = 0;
      last_idx = 0;
      for (int n = 0; n < 20 && mm_valid; n++) begin
         last_idx = mm_idx;
         cycle("full drain", 0, 0, 0, 0, 0, 0, 1);
         pops++;
      end
      chk("full occupancy", 32'(pops), 8);
      chk("full last idx", last_idx, 9);

      // Zero-length run and start during RUN
      cycle("zero start", 0, 1, 0, 0, 0, 0, 0);
      chk("zero busy", 32'(busy), 0);
      chk("zero done", 32'(done), 1);
      cycle("ign start", 0, 1, 3, 0, 0, 0, 0);
      cycle("ign s0", 0, 0, 0, 1, 32'h5, 32'h5, 0);
      cycle("ign restart", 0, 1, 7, 1, 32'h6, 32'h6, 0);
      chk("ign busy", 32'(busy), 1);
      chk("ign sample_cnt", sample_cnt, 2);
      cycle("ign s2", 0, 0, 0, 1, 32'h7, 32'h7, 0);
      chk("ign done at 3", 32'(done), 1);
      chk("ign final sample_cnt", sample_cnt, 3);

      // Reset mid-run with buffered records
      cycle("mid start", 0, 1, 10, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         cycle("mid s", 0, 0, 0, 1, 32'hAAAA_0000, (i == 1 || i == 3) ? 32'hAAAB_0000 : 32'hAAAA_0000, 0);
      chk("mid sample_cnt", sample_cnt, 5);
      chk("mid mismatch_cnt", mismatch_cnt, 2);
      cycle("mid reset", 1, 0, 0, 1, 32'h1, 32'h2, 0);
      chk("mid rst sample_cnt", sample_cnt, 0);
      chk("mid rst mismatch_cnt", mismatch_cnt, 0);
      chk("mid rst mm_valid", 32'(mm_valid), 0);
      chk("mid rst busy", 32'(busy), 0);
      cycle("mid idle", 0, 0, 0, 1, 32'h1, 32'h2, 0);
      chk("mid idle busy", 32'(busy), 0);
      chk("mid idle done", 32'(done), 0);

      // Random runs against the model
      for (int c = 0; c < 1500; c++) begin
         logic [31:0] g;
         logic [31:0] f;
         int          r;
         g = $urandom;
         r = $urandom_range(0, 3);
         if (r < 2) f = g;
         else if (r == 2) f = g ^ (32'd1 << $urandom_range(0, 31));
         else f = $urandom;
         cycle("rand", $urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
               32'($urandom_range(0, 14)), $urandom_range(0, 3) != 0, g, f,
               $urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
